// File: rtl/otter_mmio_bridge.sv
// OTTER IOBUS slave: switches, LEDs, seven-segment register and a down-counting
// interval timer that raises INTR. Read data is registered (1-cycle latency).
module otter_mmio_bridge #(
    parameter int unsigned SW_WIDTH    = 16,
    parameter int unsigned LED_WIDTH   = 16,
    parameter int unsigned TMR_WIDTH   = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [31:0]          IOBUS_ADDR,
    input  logic [31:0]          IOBUS_OUT,
    input  logic                 IOBUS_WR,
    output logic [31:0]          IOBUS_IN,
    input  logic [SW_WIDTH-1:0]  SWITCHES,
    output logic [LED_WIDTH-1:0] LEDS,
    output logic [15:0]          SSEG,
    output logic                 INTR
);

    localparam logic [29:0] A_SW     = 30'h0440_0000;
    localparam logic [29:0] A_LED    = 30'h0440_0008;
    localparam logic [29:0] A_SSEG   = 30'h0440_0010;
    localparam logic [29:0] A_TCTRL  = 30'h0440_0018;
    localparam logic [29:0] A_TLOAD  = 30'h0440_0019;
    localparam logic [29:0] A_TCOUNT = 30'h0440_001A;
    localparam logic [29:0] A_TSTAT  = 30'h0440_001B;

    localparam logic [TMR_WIDTH-1:0] TMR_ONE = TMR_WIDTH'(1);

    typedef enum logic [1:0] {
        T_IDLE,
        T_RUN,
        T_EXPIRE
    } tmr_state_t;

    logic [29:0]          word_addr;
    logic                 unused_bits;

    logic [SW_WIDTH-1:0]  sw_sync [SYNC_STAGES];

    logic                 en, irq_en, auto_reload, pending;
    logic                 en_d, irq_en_d, auto_reload_d, pending_d;
    logic [TMR_WIDTH-1:0] load, count, load_d, count_d;
    tmr_state_t           tmr_state;
    logic [31:0]          rdata;

    assign word_addr   = IOBUS_ADDR[31:2];
    assign unused_bits = ^{IOBUS_ADDR[1:0], IOBUS_OUT};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sw_sync[i] <= '0;
        end else begin
            sw_sync[0] <= SWITCHES;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sw_sync[i] <= sw_sync[i-1];
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            LEDS <= '0;
            SSEG <= '0;
        end else if (IOBUS_WR) begin
            if (word_addr == A_LED)  LEDS <= IOBUS_OUT[LED_WIDTH-1:0];
            if (word_addr == A_SSEG) SSEG <= IOBUS_OUT[15:0];
        end
    end

    always_comb begin
        tmr_state = T_IDLE;
        if (en) tmr_state = (count == '0) ? T_EXPIRE : T_RUN;
    end

    // Ordering inside this block encodes the collision rules: W1C before the
    // expiry set, and bus writes to TCTRL/TLOAD after the timer's own update.
    always_comb begin
        en_d          = en;
        irq_en_d      = irq_en;
        auto_reload_d = auto_reload;
        load_d        = load;
        count_d       = count;
        pending_d     = pending;

        if (IOBUS_WR && word_addr == A_TSTAT && IOBUS_OUT[0]) pending_d = 1'b0;

        unique case (tmr_state)
            T_RUN:    count_d = count - TMR_ONE;
            T_EXPIRE: begin
                pending_d = 1'b1;
                if (auto_reload) count_d = load;
                else             en_d    = 1'b0;
            end
            default: ;
        endcase

        if (IOBUS_WR && word_addr == A_TCTRL) begin
            en_d          = IOBUS_OUT[0];
            irq_en_d      = IOBUS_OUT[1];
            auto_reload_d = IOBUS_OUT[2];
        end
        if (IOBUS_WR && word_addr == A_TLOAD) begin
            load_d  = IOBUS_OUT[TMR_WIDTH-1:0];
            count_d = IOBUS_OUT[TMR_WIDTH-1:0];
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            en          <= 1'b0;
            irq_en      <= 1'b0;
            auto_reload <= 1'b0;
            load        <= '0;
            count       <= '0;
            pending     <= 1'b0;
        end else begin
            en          <= en_d;
            irq_en      <= irq_en_d;
            auto_reload <= auto_reload_d;
            load        <= load_d;
            count       <= count_d;
            pending     <= pending_d;
        end
    end

    assign INTR = pending & irq_en;

    always_comb begin
        rdata = '0;
        unique case (word_addr)
            A_SW:     rdata = 32'(sw_sync[SYNC_STAGES-1]);
            A_LED:    rdata = 32'(LEDS);
            A_SSEG:   rdata = {16'h0000, SSEG};
            A_TCTRL:  rdata = {29'd0, auto_reload, irq_en, en};
            A_TLOAD:  rdata = 32'(load);
            A_TCOUNT: rdata = 32'(count);
            A_TSTAT:  rdata = {31'd0, pending};
            default:  rdata = '0;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) IOBUS_IN <= '0;
        else       IOBUS_IN <= rdata;
    end

endmodule
